// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared constants, types and helpers for the six-digit hex
// display front-end (hex_disp_ctrl and its blink_timer).
//   NDIG     - number of seven-segment digits driven
//   NIB_W    - bits per displayed digit
//   cursor_t - cursor digit index; values >= NDIG mean "no cursor"
//   CUR_NONE - cursor value used at reset (no digit blinks)
//   lz_mask  - per-digit leading-zero blanking mask for a displayed value
package hex_disp_pkg;

  localparam int NDIG  = 6;
  localparam int NIB_W = 4;

  typedef logic [2:0] cursor_t;

  localparam cursor_t CUR_NONE = 3'd7;

  // Bit i (i > 0) is set when nibbles i..NDIG-1 of val are all zero, i.e.
  // digit i is a leading zero. Digit 0 is never flagged so a value of zero
  // still shows a single "0".
  function automatic logic [NDIG-1:0] lz_mask(input logic [NDIG*NIB_W-1:0] val);
    logic [NDIG-1:0] mask_v;
    logic            upper_zero_v;
    mask_v       = '0;
    upper_zero_v = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      upper_zero_v = upper_zero_v & (val[i*NIB_W +: NIB_W] == 4'h0);
      mask_v[i]    = upper_zero_v;
    end
    return mask_v;
  endfunction

endpackage

// File: rtl/hex_disp_ctrl_blink_timer.sv
// blink_timer: free-running blink phase generator for the cursor digit.
//   clk     - system clock
//   rst     - asynchronous active-high reset (counter 0, phase 1)
//   restart - restart the blink cycle at the visible phase, counter at 0
//   phase   - 1 = cursor visible half-period, toggles every BLINK_DIV cycles
// Parameter BLINK_DIV (>= 2): clock cycles per blink phase.
module blink_timer #(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Phase counter; a restart outranks a coincident wrap so an edit always
  // shows the cursor for a full phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      cnt_r <= '0;
      phase <= 1'b1;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      phase <= ~phase;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_disp_ctrl.sv
// hex_disp_ctrl: display front-end for six seven-segment digits. Holds a
// 24-bit value and a cursor digit, and produces one nibble plus one enable
// per digit for the downstream seven-segment decoders. The cursor digit
// blinks; an edit (load or cursor write) restarts the blink visible.
//   clk         - system clock
//   rst         - asynchronous active-high reset
//   load        - capture value_in
//   value_in    - value to display, nibble i -> digit i (digit 0 rightmost)
//   cursor_we   - capture cursor_in
//   cursor_in   - cursor digit 0..5; 6 or 7 = no cursor
//   disp_on     - global display enable (pure gate on digit_en)
//   digit       - nibble per digit, digit[4i+3:4i]
//   digit_en    - per-digit decoder enable
//   blink_phase - 1 = cursor visible half-period
// Optional feature macro HEX_DISP_LZ_EN: leading-zero suppression (the
// cursor digit is exempt from it but still blinks).
module hex_disp_ctrl
  import hex_disp_pkg::*;
#(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [NDIG*NIB_W-1:0]  value_in,
  input  logic                   cursor_we,
  input  cursor_t                cursor_in,
  input  logic                   disp_on,
  output logic [NDIG*NIB_W-1:0]  digit,
  output logic [NDIG-1:0]        digit_en,
  output logic                   blink_phase
);

  logic [NDIG*NIB_W-1:0] val_r;
  cursor_t               cur_r;
  logic                  phase_s;
  logic                  restart_s;
  logic [NDIG-1:0]       cur_sel_s;
  logic [NDIG-1:0]       blink_blank_s;
  logic [NDIG-1:0]       lz_blank_s;

  assign restart_s = load | cursor_we;

  blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_s),
    .phase   (phase_s)
  );

  // Value and cursor registers; both may be written on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_r <= '0;
      cur_r <= CUR_NONE;
    end else begin
      if (load) begin
        val_r <= value_in;
      end
      if (cursor_we) begin
        cur_r <= cursor_in;
      end
    end
  end

  // Per-digit enable: cursor values 6/7 match no digit, so blinking is
  // naturally disabled for them.
  always_comb begin
    cur_sel_s     = '0;
    blink_blank_s = '0;
    lz_blank_s    = '0;
    for (int i = 0; i < NDIG; i++) begin
      cur_sel_s[i]     = (cur_r == 3'(i));
      blink_blank_s[i] = cur_sel_s[i] & ~phase_s;
    end
`ifdef HEX_DISP_LZ_EN
    lz_blank_s = lz_mask(val_r) & ~cur_sel_s;
`else
    lz_blank_s = '0;
`endif
    digit_en = {NDIG{disp_on}} & ~blink_blank_s & ~lz_blank_s;
  end

  assign digit       = val_r;
  assign blink_phase = phase_s;

endmodule
